// File: rtl/i2s_rx_module.sv
// i2s_rx_module: I2S slave-side receiver, deserialises left/right 24-bit words into the sck domain.
// BCK/LRCK/DIN are synchronised to sck; all state advances on the detected BCK rising edge.
module i2s_rx_module #(
  parameter int SLOT_BITS = 32,
  parameter int DATA_BITS = 24
) (
  input  logic                 sck,
  input  logic                 reset,
  input  logic                 BCK,
  input  logic                 LRCK,
  input  logic                 DIN,
  output logic [DATA_BITS-1:0] tx_real,
  output logic [DATA_BITS-1:0] tx_imag,
  output logic                 sample_valid,
  output logic                 frame_error
);
  localparam int CW = $clog2(SLOT_BITS + 2);
  localparam logic [CW-1:0] DB = CW'(DATA_BITS);
  localparam logic [CW-1:0] MAXC = CW'(SLOT_BITS + 1);
  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;
  state_t state_q, state_d;
  logic [2:0] bck_q, bck_d;
  logic [1:0] lr_s_q, lr_s_d, din_s_q, din_s_d;
  logic lr_prev_q, lr_prev_d, left_ok_q, left_ok_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d, cnt_inc;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, left_hold_q, left_hold_d;
  logic [DATA_BITS-1:0] tx_real_q, tx_real_d, tx_imag_q, tx_imag_d;
  logic sv_q, sv_d, fe_q, fe_d;
  logic bck_rise, lr, d, trans, full;
  always_comb begin
    bck_d = {bck_q[1:0], BCK};
    lr_s_d = {lr_s_q[0], LRCK};
    din_s_d = {din_s_q[0], DIN};
    bck_rise = bck_q[1] & ~bck_q[2];
    lr = lr_s_q[1];
    d = din_s_q[1];
    trans = lr ^ lr_prev_q;
    full = bit_cnt_q >= DB;
    cnt_inc = (bit_cnt_q == MAXC) ? bit_cnt_q : bit_cnt_q + CW'(1);
    state_d = state_q;
    lr_prev_d = lr_prev_q;
    left_ok_d = left_ok_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d = shreg_q;
    left_hold_d = left_hold_q;
    tx_real_d = tx_real_q;
    tx_imag_d = tx_imag_q;
    sv_d = 1'b0;
    fe_d = 1'b0;
    if (bck_rise) begin
      lr_prev_d = lr;
      case (state_q)
        SYNC: begin
          if (trans && !lr) begin
            bit_cnt_d = '0;
            state_d = LEFT;
          end
        end
        default: begin
          if (trans) begin
            // the transition rise carries the old slot's LSB and is never shifted
            bit_cnt_d = '0;
            if (state_q == LEFT) begin
              left_hold_d = full ? shreg_q : left_hold_q;
              left_ok_d = full;
              fe_d = !full;
              state_d = RIGHT;
            end else begin
              sv_d = full && left_ok_q;
              tx_real_d = sv_d ? left_hold_q : tx_real_q;
              tx_imag_d = sv_d ? shreg_q : tx_imag_q;
              fe_d = !full;
              left_ok_d = 1'b0;
              state_d = LEFT;
            end
          end else begin
            shreg_d = full ? shreg_q : {shreg_q[DATA_BITS-2:0], d};
            bit_cnt_d = cnt_inc;
            if (cnt_inc == MAXC) begin
              fe_d = 1'b1;
              left_ok_d = 1'b0;
              state_d = SYNC;
            end
          end
        end
      endcase
    end
  end
  always_ff @(posedge sck) begin
    if (reset) begin
      state_q <= SYNC;
      bck_q <= '0;
      lr_s_q <= '0;
      din_s_q <= '0;
      lr_prev_q <= 1'b0;
      left_ok_q <= 1'b0;
      bit_cnt_q <= '0;
      shreg_q <= '0;
      left_hold_q <= '0;
      tx_real_q <= '0;
      tx_imag_q <= '0;
      sv_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bck_q <= bck_d;
      lr_s_q <= lr_s_d;
      din_s_q <= din_s_d;
      lr_prev_q <= lr_prev_d;
      left_ok_q <= left_ok_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q <= shreg_d;
      left_hold_q <= left_hold_d;
      tx_real_q <= tx_real_d;
      tx_imag_q <= tx_imag_d;
      sv_q <= sv_d;
      fe_q <= fe_d;
    end
  end
  assign tx_real = tx_real_q;
  assign tx_imag = tx_imag_q;
  assign sample_valid = sv_q;
  assign frame_error = fe_q;
endmodule

// File: tb/tb_i2s_rx_module.sv
// tb_i2s_rx_module: directed frame vectors plus reset, short-slot and stuck-LRCK sequences.
module tb_i2s_rx_module;
  logic sck = 1'b0, reset = 1'b1, BCK = 1'b0, LRCK = 1'b1, DIN = 1'b0;
  logic [23:0] tx_real, tx_imag;
  logic sample_valid, frame_error;
  i2s_rx_module dut (
    .sck(sck), .reset(reset), .BCK(BCK), .LRCK(LRCK), .DIN(DIN),
    .tx_real(tx_real), .tx_imag(tx_imag),
    .sample_valid(sample_valid), .frame_error(frame_error)
  );
  always #5 sck = ~sck;
  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic [23:0] er;
    logic [23:0] ei;
  } vec_t;
  vec_t vt[5];
  int total = 0, bad = 0, sv_cnt = 0, fe_cnt = 0, n0, f0;
  longint cyc = 0, last_sv = 0;
  bit spc_on = 1'b0, primed = 1'b0;
  logic last_bit = 1'b0;
  logic [47:0] exp_q[$];
  logic [47:0] mon_e;
  logic [31:0] l, r;
  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  always @(posedge sck) cyc++;
  // scoreboard: every sample_valid must match the oldest expected pair
  always @(negedge sck) begin
    if (frame_error) fe_cnt++;
    if (sample_valid) begin
      sv_cnt++;
      if (spc_on && last_sv != 0) check("sv_spacing", 48'(cyc - last_sv), 48'd1280);
      last_sv = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_sv: got pair %h %h, none expected", tx_real, tx_imag);
      end else begin
        mon_e = exp_q.pop_front();
        check("pair", {tx_real, tx_imag}, mon_e);
      end
    end
  end
  task automatic send_bit(input logic lr, input logic d);
    @(negedge sck);
    LRCK = lr;
    DIN = d;
    BCK = 1'b0;
    repeat (10) @(negedge sck);
    BCK = 1'b1;
    repeat (9) @(negedge sck);
  endtask
  // I2S: data lags LRCK by one BCK, so period 0 of a slot carries the previous slot's LSB
  task automatic slot(input logic lr, input logic [31:0] w, input int n, input int rel);
    for (int i = 0; i < n; i++) begin
      if (i == rel) reset = 1'b0;
      if (!(i == 0 && primed)) send_bit(lr, i == 0 ? last_bit : w[32-i]);
    end
    primed = 1'b0;
    last_bit = w[32-n];
  endtask
  task automatic frame(input logic [31:0] fl, input logic [31:0] fr);
    slot(1'b0, fl, 32, -1);
    slot(1'b1, fr, 32, -1);
  endtask
  task automatic close_frame();
    send_bit(1'b0, last_bit);
    primed = 1'b1;
  endtask
  initial begin
    vt[0] = '{32'h12345600, 32'hABCDEF00, 24'h123456, 24'hABCDEF};
    vt[1] = '{32'h123456FF, 32'hABCDEFFF, 24'h123456, 24'hABCDEF};
    vt[2] = '{32'h7FFFFF00, 32'h800000AA, 24'h7FFFFF, 24'h800000};
    vt[3] = '{32'hFFFFFF55, 32'h00000001, 24'hFFFFFF, 24'h000000};
    vt[4] = '{32'h00000100, 32'hA5A5A5C3, 24'h000001, 24'hA5A5A5};
    repeat (5) @(negedge sck);
    check("rst_out", {tx_real, tx_imag}, 48'd0);
    check("rst_pulse", 48'({sample_valid, frame_error}), 48'd0);
    reset = 1'b0;
    repeat (10) send_bit(1'b1, 1'b1);
    check("idle_sv", 48'(sv_cnt), 48'd0);
    check("idle_fe", 48'(fe_cnt), 48'd0);
    for (int i = 0; i < 5; i++) begin
      n0 = sv_cnt;
      exp_q.push_back({vt[i].er, vt[i].ei});
      frame(vt[i].l, vt[i].r);
      close_frame();
      check("vec_sv", 48'(sv_cnt - n0), 48'd1);
      check("vec_real", 48'(tx_real), 48'(vt[i].er));
      check("vec_imag", 48'(tx_imag), 48'(vt[i].ei));
    end
    check("vec_fe", 48'(fe_cnt), 48'd0);
    n0 = sv_cnt;
    f0 = fe_cnt;
    spc_on = 1'b1;
    last_sv = 0;
    for (int k = 0; k < 30; k++) begin
      l = $urandom;
      r = $urandom;
      exp_q.push_back({l[31:8], r[31:8]});
      frame(l, r);
    end
    close_frame();
    spc_on = 1'b0;
    check("burst_sv", 48'(sv_cnt - n0), 48'd30);
    check("burst_fe", 48'(fe_cnt - f0), 48'd0);
    n0 = sv_cnt;
    f0 = fe_cnt;
    reset = 1'b1;
    slot(1'b0, $urandom, 32, -1);
    check("midrst_out", {tx_real, tx_imag}, 48'd0);
    slot(1'b1, $urandom, 32, 10);
    exp_q.push_back({24'h7FFFFF, 24'h800000});
    frame(32'h7FFFFF12, 32'h80000034);
    close_frame();
    check("midrst_sv", 48'(sv_cnt - n0), 48'd1);
    check("midrst_pair", {tx_real, tx_imag}, {24'h7FFFFF, 24'h800000});
    check("midrst_fe", 48'(fe_cnt - f0), 48'd0);
    n0 = sv_cnt;
    f0 = fe_cnt;
    slot(1'b0, 32'hDEADBEEF, 17, -1);
    slot(1'b1, $urandom, 32, -1);
    close_frame();
    check("short_fe", 48'(fe_cnt - f0), 48'd1);
    check("short_sv", 48'(sv_cnt - n0), 48'd0);
    check("short_hold", {tx_real, tx_imag}, {24'h7FFFFF, 24'h800000});
    exp_q.push_back({24'h13579B, 24'h2468AC});
    frame(32'h13579BDF, 32'h2468ACE0);
    close_frame();
    check("short_next_sv", 48'(sv_cnt - n0), 48'd1);
    check("short_next_pair", {tx_real, tx_imag}, {24'h13579B, 24'h2468AC});
    n0 = sv_cnt;
    f0 = fe_cnt;
    repeat (40) send_bit(1'b0, 1'($urandom));
    primed = 1'b0;
    check("stuck_fe", 48'(fe_cnt - f0), 48'd1);
    check("stuck_sv", 48'(sv_cnt - n0), 48'd0);
    slot(1'b1, $urandom, 32, -1);
    exp_q.push_back({24'h0F0F0F, 24'hF0F0F0});
    frame(32'h0F0F0F00, 32'hF0F0F0FF);
    close_frame();
    check("stuck_rec_sv", 48'(sv_cnt - n0), 48'd1);
    check("stuck_rec_fe", 48'(fe_cnt - f0), 48'd1);
    check("stuck_rec_pair", {tx_real, tx_imag}, {24'h0F0F0F, 24'hF0F0F0});
    check("queue_empty", 48'(exp_q.size()), 48'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
